// File: rtl/sdram_readback_checker.sv
// Reads LENGTH words back from the SDRAM controller's read FIFO and checks them
// against an incrementing pattern that starts at SEED, reporting the error count and the first mismatch.
module sdram_readback_checker #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned LENGTH    = 256,
  parameter int unsigned LOAD_WAIT = 16
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              START,
  input  logic [DATA_W-1:0] SEED,
  input  logic              RD_EMPTY,
  input  logic [DATA_W-1:0] RD_DATA,
  output logic              RD,
  output logic              RD_LOAD,
  output logic              BUSY,
  output logic              DONE,
  output logic              PASS,
  output logic [7:0]        ERR_CNT,
  output logic [15:0]       FIRST_ERR_IDX,
  output logic [DATA_W-1:0] FIRST_ERR_DATA
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_READ,
    S_FLUSH,
    S_FIN
  } state_t;

  localparam logic [15:0] LEN16     = 16'(LENGTH);
  localparam logic [15:0] LAST_IDX  = 16'(LENGTH - 1);
  localparam logic [15:0] WAIT_LAST = (LOAD_WAIT == 0) ? 16'd0 : 16'(LOAD_WAIT - 1);

  state_t              state_q, state_d;
  logic [15:0]         wait_q, wait_d;
  logic [15:0]         rd_idx_q, rd_idx_d;
  logic [15:0]         cmp_idx_q, cmp_idx_d;
  logic [DATA_W-1:0]   exp_q, exp_d;
  logic                rd_q;
  logic                rd;
  logic                rd_load_q, rd_load_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [7:0]          err_cnt_q, err_cnt_d;
  logic [15:0]         first_idx_q, first_idx_d;
  logic [DATA_W-1:0]   first_data_q, first_data_d;

  // The pop strobe must react to RD_EMPTY in the same cycle, so it is not registered.
  assign rd = (state_q == S_READ) && !RD_EMPTY && (rd_idx_q < LEN16);

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    rd_idx_d     = rd_idx_q;
    cmp_idx_d    = cmp_idx_q;
    exp_d        = exp_q;
    rd_load_d    = 1'b0;
    busy_d       = busy_q;
    done_d       = done_q;
    pass_d       = pass_q;
    err_cnt_d    = err_cnt_q;
    first_idx_d  = first_idx_q;
    first_data_d = first_data_q;

    // ERR_CNT never returns to zero within a run, so zero marks "no mismatch seen yet".
    if (rd_q) begin
      exp_d     = exp_q + DATA_W'(1);
      cmp_idx_d = cmp_idx_q + 16'd1;
      if (RD_DATA != exp_q) begin
        if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        if (err_cnt_q == 8'd0) begin
          first_idx_d  = cmp_idx_q;
          first_data_d = RD_DATA;
        end
      end
    end

    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d      = S_LOAD;
          rd_load_d    = 1'b1;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          pass_d       = 1'b0;
          err_cnt_d    = '0;
          first_idx_d  = '0;
          first_data_d = '0;
          rd_idx_d     = '0;
          cmp_idx_d    = '0;
          exp_d        = SEED;
        end
      end
      S_LOAD: begin
        state_d = S_WAIT;
        wait_d  = '0;
      end
      S_WAIT: begin
        if (wait_q == WAIT_LAST) state_d = S_READ;
        else                     wait_d  = wait_q + 16'd1;
      end
      S_READ: begin
        if (rd) begin
          rd_idx_d = rd_idx_q + 16'd1;
          if (rd_idx_q == LAST_IDX) state_d = S_FLUSH;
        end
      end
      S_FLUSH: state_d = S_FIN;
      S_FIN: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        pass_d  = (err_cnt_q == 8'd0);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= S_IDLE;
      wait_q       <= '0;
      rd_idx_q     <= '0;
      cmp_idx_q    <= '0;
      exp_q        <= '0;
      rd_q         <= 1'b0;
      rd_load_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_cnt_q    <= '0;
      first_idx_q  <= '0;
      first_data_q <= '0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      rd_idx_q     <= rd_idx_d;
      cmp_idx_q    <= cmp_idx_d;
      exp_q        <= exp_d;
      rd_q         <= rd;
      rd_load_q    <= rd_load_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      err_cnt_q    <= err_cnt_d;
      first_idx_q  <= first_idx_d;
      first_data_q <= first_data_d;
    end
  end

  assign RD             = rd;
  assign RD_LOAD        = rd_load_q;
  assign BUSY           = busy_q;
  assign DONE           = done_q;
  assign PASS           = pass_q;
  assign ERR_CNT        = err_cnt_q;
  assign FIRST_ERR_IDX  = first_idx_q;
  assign FIRST_ERR_DATA = first_data_q;

endmodule

// File: tb/tb_sdram_readback_checker.sv
// Bench for sdram_readback_checker: three instances (LENGTH 256/32/300) each fed by a
// small read-FIFO model, driven from a vector table plus hand-written multi-cycle sequences.
module tb_sdram_readback_checker;

  localparam int N = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start   [N];
  logic [7:0] seed    [N];
  logic       empty   [N];
  logic [7:0] rdata   [N];
  logic       rd      [N];
  logic       rd_load [N];
  logic       busy    [N];
  logic       done    [N];
  logic       pass    [N];
  logic [7:0] err     [N];
  logic [15:0] fidx   [N];
  logic [7:0] fdata   [N];

  logic [7:0] base      [N];
  int         cidx      [N];
  logic [7:0] cval      [N];
  logic       all_wrong [N];
  logic       stall_en  [N];
  logic       clr       [N];

  int pop_cnt   [N];
  int load_cnt  [N];
  int bad_rd    [N];
  int stall_cyc [N];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sdram_readback_checker #(.DATA_W(8), .LENGTH(256), .LOAD_WAIT(16)) u0 (
    .CLK(clk), .RESET_N(rst_n), .START(start[0]), .SEED(seed[0]), .RD_EMPTY(empty[0]),
    .RD_DATA(rdata[0]), .RD(rd[0]), .RD_LOAD(rd_load[0]), .BUSY(busy[0]), .DONE(done[0]),
    .PASS(pass[0]), .ERR_CNT(err[0]), .FIRST_ERR_IDX(fidx[0]), .FIRST_ERR_DATA(fdata[0]));

  sdram_readback_checker #(.DATA_W(8), .LENGTH(32), .LOAD_WAIT(16)) u1 (
    .CLK(clk), .RESET_N(rst_n), .START(start[1]), .SEED(seed[1]), .RD_EMPTY(empty[1]),
    .RD_DATA(rdata[1]), .RD(rd[1]), .RD_LOAD(rd_load[1]), .BUSY(busy[1]), .DONE(done[1]),
    .PASS(pass[1]), .ERR_CNT(err[1]), .FIRST_ERR_IDX(fidx[1]), .FIRST_ERR_DATA(fdata[1]));

  sdram_readback_checker #(.DATA_W(8), .LENGTH(300), .LOAD_WAIT(16)) u2 (
    .CLK(clk), .RESET_N(rst_n), .START(start[2]), .SEED(seed[2]), .RD_EMPTY(empty[2]),
    .RD_DATA(rdata[2]), .RD(rd[2]), .RD_LOAD(rd_load[2]), .BUSY(busy[2]), .DONE(done[2]),
    .PASS(pass[2]), .ERR_CNT(err[2]), .FIRST_ERR_IDX(fidx[2]), .FIRST_ERR_DATA(fdata[2]));

  function automatic logic [7:0] word_of(int i, int k);
    logic [7:0] v;
    v = base[i] + 8'(k);
    if (all_wrong[i]) v = ~v;
    if (k == cidx[i]) v = cval[i];
    return v;
  endfunction

  // FIFO goes empty for 10 cycles once 100 words have been popped, when stalling is enabled.
  always_comb begin
    for (int i = 0; i < N; i++)
      empty[i] = stall_en[i] && (pop_cnt[i] == 100) && (stall_cyc[i] < 10);
  end

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (clr[i]) begin
        pop_cnt[i]   <= 0;
        load_cnt[i]  <= 0;
        bad_rd[i]    <= 0;
        stall_cyc[i] <= 0;
      end else begin
        if (rd[i]) begin
          rdata[i]   <= word_of(i, pop_cnt[i]);
          pop_cnt[i] <= pop_cnt[i] + 1;
        end
        if (rd[i] && empty[i]) bad_rd[i]    <= bad_rd[i] + 1;
        if (rd_load[i])        load_cnt[i]  <= load_cnt[i] + 1;
        if (empty[i])          stall_cyc[i] <= stall_cyc[i] + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic setup(input int i, input logic [7:0] b, input int ci, input logic [7:0] cv,
                       input logic aw, input logic st);
    base[i] = b; cidx[i] = ci; cval[i] = cv; all_wrong[i] = aw; stall_en[i] = st;
    clr[i] = 1'b1;
    @(negedge clk);
    clr[i] = 1'b0;
  endtask

  task automatic pulse_start(input int i, input logic [7:0] s);
    start[i] = 1'b1;
    seed[i]  = s;
    @(negedge clk);
    start[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input string name);
    int n;
    n = 0;
    while (!done[i] && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({name, " done"}, 32'(done[i]), 32'd1);
  endtask

  typedef struct {
    int         dut;
    logic [7:0] seed;
    logic [7:0] base;
    int         cidx;
    logic [7:0] cval;
    logic       aw;
    logic       st;
    logic       exp_pass;
    int         exp_err;
    int         exp_fidx;
    logic [7:0] exp_fdata;
    int         exp_rd;
  } vec_t;

  vec_t vecs [8];

  initial begin
    for (int i = 0; i < N; i++) begin
      start[i] = 1'b0; seed[i] = '0; base[i] = '0; cidx[i] = -1; cval[i] = '0;
      all_wrong[i] = 1'b0; stall_en[i] = 1'b0; clr[i] = 1'b1;
    end
    //          dut seed   base   cidx cval   aw    st    pass  err  fidx fdata  rd
    vecs[0] = '{0, 8'h00, 8'h00, -1,  8'h00, 1'b0, 1'b0, 1'b1, 0,   0,   8'h00, 256};
    vecs[1] = '{0, 8'h00, 8'h00, 37,  8'hFF, 1'b0, 1'b0, 1'b0, 1,   37,  8'hFF, 256};
    vecs[2] = '{1, 8'hF0, 8'hF0, -1,  8'h00, 1'b0, 1'b0, 1'b1, 0,   0,   8'h00, 32};
    vecs[3] = '{0, 8'h00, 8'h00, -1,  8'h00, 1'b0, 1'b1, 1'b1, 0,   0,   8'h00, 256};
    vecs[4] = '{2, 8'h00, 8'h00, -1,  8'h00, 1'b1, 1'b0, 1'b0, 255, 0,   8'hFF, 300};
    vecs[5] = '{0, 8'h55, 8'h55, 255, 8'h00, 1'b0, 1'b0, 1'b0, 1,   255, 8'h00, 256};
    vecs[6] = '{2, 8'h10, 8'h10, -1,  8'h00, 1'b0, 1'b0, 1'b1, 0,   0,   8'h00, 300};
    vecs[7] = '{1, 8'h00, 8'h01, -1,  8'h00, 1'b0, 1'b0, 1'b0, 32,  0,   8'h01, 32};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset RD",      32'(rd[0]),      32'd0);
    chk("reset RD_LOAD", 32'(rd_load[0]), 32'd0);
    chk("reset BUSY",    32'(busy[0]),    32'd0);
    chk("reset DONE",    32'(done[0]),    32'd0);
    chk("reset PASS",    32'(pass[0]),    32'd0);
    chk("reset ERR_CNT", 32'(err[0]),     32'd0);
    chk("reset FIDX",    32'(fidx[0]),    32'd0);
    chk("reset FDATA",   32'(fdata[0]),   32'd0);
    for (int i = 0; i < N; i++) clr[i] = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[v]) begin
      int d;
      d = vecs[v].dut;
      setup(d, vecs[v].base, vecs[v].cidx, vecs[v].cval, vecs[v].aw, vecs[v].st);
      pulse_start(d, vecs[v].seed);
      wait_done(d, $sformatf("v%0d", v));
      @(negedge clk);
      chk($sformatf("v%0d PASS", v),      32'(pass[d]),      32'(vecs[v].exp_pass));
      chk($sformatf("v%0d ERR_CNT", v),   32'(err[d]),       32'(vecs[v].exp_err));
      chk($sformatf("v%0d FIDX", v),      32'(fidx[d]),      32'(vecs[v].exp_fidx));
      chk($sformatf("v%0d FDATA", v),     32'(fdata[d]),     32'(vecs[v].exp_fdata));
      chk($sformatf("v%0d rd pulses", v), 32'(pop_cnt[d]),   32'(vecs[v].exp_rd));
      chk($sformatf("v%0d RD_LOAD", v),   32'(load_cnt[d]),  32'd1);
      chk($sformatf("v%0d rd on empty", v), 32'(bad_rd[d]),  32'd0);
      chk($sformatf("v%0d BUSY", v),      32'(busy[d]),      32'd0);
      chk($sformatf("v%0d stall cyc", v), 32'(stall_cyc[d]), vecs[v].st ? 32'd10 : 32'd0);
    end

    // BUSY / RD_LOAD timing right after START, with DONE from the previous run cleared
    setup(0, 8'h00, -1, 8'h00, 1'b0, 1'b0);
    chk("pre DONE", 32'(done[0]), 32'd1);
    chk("pre BUSY", 32'(busy[0]), 32'd0);
    pulse_start(0, 8'h00);
    chk("t1 BUSY",    32'(busy[0]),    32'd1);
    chk("t1 RD_LOAD", 32'(rd_load[0]), 32'd1);
    chk("t1 DONE",    32'(done[0]),    32'd0);
    @(negedge clk);
    chk("t2 RD_LOAD", 32'(rd_load[0]), 32'd0);
    chk("t2 BUSY",    32'(busy[0]),    32'd1);
    wait_done(0, "timing");
    chk("timing BUSY at DONE", 32'(busy[0]), 32'd0);
    chk("timing PASS", 32'(pass[0]), 32'd1);

    // START issued mid-run must not reseed or restart
    setup(1, 8'hF0, -1, 8'h00, 1'b0, 1'b0);
    pulse_start(1, 8'hF0);
    repeat (2) @(negedge clk);
    pulse_start(1, 8'h00);
    wait_done(1, "ignore");
    chk("ignore PASS",    32'(pass[1]),     32'd1);
    chk("ignore RD_LOAD", 32'(load_cnt[1]), 32'd1);
    chk("ignore rd",      32'(pop_cnt[1]),  32'd32);

    // Asynchronous reset in the middle of READ with an error already counted
    setup(0, 8'h00, 5, 8'hAA, 1'b0, 1'b0);
    pulse_start(0, 8'h00);
    begin
      int n;
      n = 0;
      while (pop_cnt[0] < 50 && n < 1000) begin
        @(negedge clk);
        n++;
      end
    end
    chk("mid pop reached", 32'(pop_cnt[0] >= 50), 32'd1);
    chk("mid ERR_CNT", 32'(err[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid-rst RD",      32'(rd[0]),      32'd0);
    chk("mid-rst RD_LOAD", 32'(rd_load[0]), 32'd0);
    chk("mid-rst BUSY",    32'(busy[0]),    32'd0);
    chk("mid-rst DONE",    32'(done[0]),    32'd0);
    chk("mid-rst PASS",    32'(pass[0]),    32'd0);
    chk("mid-rst ERR_CNT", 32'(err[0]),     32'd0);
    chk("mid-rst FIDX",    32'(fidx[0]),    32'd0);
    chk("mid-rst FDATA",   32'(fdata[0]),   32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-rst idle BUSY", 32'(busy[0]), 32'd0);
    setup(0, 8'h00, -1, 8'h00, 1'b0, 1'b0);
    pulse_start(0, 8'h00);
    wait_done(0, "rerun");
    @(negedge clk);
    chk("rerun PASS",    32'(pass[0]),     32'd1);
    chk("rerun ERR_CNT", 32'(err[0]),      32'd0);
    chk("rerun RD_LOAD", 32'(load_cnt[0]), 32'd1);
    chk("rerun rd",      32'(pop_cnt[0]),  32'd256);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
